// File: rtl/ram_sp_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with a shared tri-state data bus.
// Define RAM_ARB_RR_EN for round-robin contention; otherwise requester A has fixed priority.
module ram_sp_arbiter #(
    parameter int data_width    = 8,
    parameter int address_width = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_a,
    input  logic                     req_b,
    input  logic                     we_a,
    input  logic                     we_b,
    input  logic [address_width-1:0] addr_a,
    input  logic [address_width-1:0] addr_b,
    input  logic [data_width-1:0]    wdata_a,
    input  logic [data_width-1:0]    wdata_b,
    output logic                     done_a,
    output logic                     done_b,
    output logic [data_width-1:0]    rdata,
    output logic [address_width-1:0] ram_address,
    output logic                     ram_wr_rd_en,
    inout  wire  [data_width-1:0]    ram_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     we_q, we_d;
    logic [data_width-1:0]    wdata_q, wdata_d;
    logic                     grant_b_q, grant_b_d;
    logic                     done_a_q, done_a_d;
    logic                     done_b_q, done_b_d;
    logic                     wr_en_q, wr_en_d;
    logic                     drive_q, drive_d;
    logic [address_width-1:0] ram_address_q, ram_address_d;
    logic [data_width-1:0]    rdata_q, rdata_d;
    logic                     pick_b_s;
    logic                     sel_we_s;
    logic [address_width-1:0] sel_addr_s;
    logic [data_width-1:0]    sel_wdata_s;

`ifdef RAM_ARB_RR_EN
    logic prefer_b_q, prefer_b_d;

    // Round-robin winner: under contention the requester not served last wins.
    always_comb begin
        pick_b_s   = req_b && (!req_a || prefer_b_q);
        prefer_b_d = prefer_b_q;
        if ((state_q == IDLE) && (req_a || req_b)) begin
            prefer_b_d = !pick_b_s;
        end else begin
            prefer_b_d = prefer_b_q;
        end
    end

    // Pointer resets to favour requester A and moves only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prefer_b_q <= 1'b0;
        end else begin
            prefer_b_q <= prefer_b_d;
        end
    end
`else
    // Fixed priority winner: A always wins when both request.
    always_comb begin
        pick_b_s = req_b && !req_a;
    end
`endif

    // Mux the winning requester's operands.
    always_comb begin
        sel_we_s    = pick_b_s ? we_b    : we_a;
        sel_addr_s  = pick_b_s ? addr_b  : addr_a;
        sel_wdata_s = pick_b_s ? wdata_b : wdata_a;
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        grant_b_d     = grant_b_q;
        done_a_d      = 1'b0;
        done_b_d      = 1'b0;
        wr_en_d       = 1'b0;
        drive_d       = 1'b0;
        ram_address_d = ram_address_q;
        rdata_d       = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    state_d       = ACCESS;
                    we_d          = sel_we_s;
                    wdata_d       = sel_wdata_s;
                    grant_b_d     = pick_b_s;
                    ram_address_d = sel_addr_s;
                    wr_en_d       = sel_we_s;
                    drive_d       = sel_we_s;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d  = RESP;
                done_a_d = !grant_b_q;
                done_b_d = grant_b_q;
                if (!we_q) begin
                    rdata_d = ram_data;
                end else begin
                    rdata_d = rdata_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            wdata_q       <= {data_width{1'b0}};
            grant_b_q     <= 1'b0;
            done_a_q      <= 1'b0;
            done_b_q      <= 1'b0;
            wr_en_q       <= 1'b0;
            drive_q       <= 1'b0;
            ram_address_q <= {address_width{1'b0}};
            rdata_q       <= {data_width{1'b0}};
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            grant_b_q     <= grant_b_d;
            done_a_q      <= done_a_d;
            done_b_q      <= done_b_d;
            wr_en_q       <= wr_en_d;
            drive_q       <= drive_d;
            ram_address_q <= ram_address_d;
            rdata_q       <= rdata_d;
        end
    end

    // The bus is driven only by a registered enable that is high in a write ACCESS.
    assign ram_data     = drive_q ? wdata_q : {data_width{1'bz}};
    assign done_a       = done_a_q;
    assign done_b       = done_b_q;
    assign rdata        = rdata_q;
    assign ram_address  = ram_address_q;
    assign ram_wr_rd_en = wr_en_q;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Directed bench for ram_sp_arbiter: vector table of single-requester transactions
// plus hand-written contention and reset-mid-access sequences, against a small RAM model.
module tb_ram_sp_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req_a, req_b, we_a, we_b;
    logic [3:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;
    logic       done_a, done_b, ram_wr_rd_en;
    logic [7:0] rdata;
    logic [3:0] ram_address;
    wire  [7:0] ram_data;

    logic [7:0] mem [16];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       ra;
        logic       rb;
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_bus;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    ram_sp_arbiter #(.data_width(8), .address_width(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_a        (req_a),
        .req_b        (req_b),
        .we_a         (we_a),
        .we_b         (we_b),
        .addr_a       (addr_a),
        .addr_b       (addr_b),
        .wdata_a      (wdata_a),
        .wdata_b      (wdata_b),
        .done_a       (done_a),
        .done_b       (done_b),
        .rdata        (rdata),
        .ram_address  (ram_address),
        .ram_wr_rd_en (ram_wr_rd_en),
        .ram_data     (ram_data)
    );

    // RAM model: drives the bus whenever it is in read mode, writes on the clock edge.
    assign ram_data = ram_wr_rd_en ? 8'hzz : mem[ram_address];

    always @(posedge clk) begin
        if (ram_wr_rd_en) begin
            mem[ram_address] <= ram_data;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst done_a", 32'(done_a), 32'd0);
        chk("rst done_b", 32'(done_b), 32'd0);
        chk("rst wr_en", 32'(ram_wr_rd_en), 32'd0);
        chk("rst ram_address", 32'(ram_address), 32'd0);
        chk("rst rdata", 32'(rdata), 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        @(negedge clk);
        req_a   = v.ra;
        req_b   = v.rb;
        we_a    = v.ra ? v.we    : !v.we;
        we_b    = v.rb ? v.we    : !v.we;
        addr_a  = v.ra ? v.addr  : ~v.addr;
        addr_b  = v.rb ? v.addr  : ~v.addr;
        wdata_a = v.ra ? v.wdata : ~v.wdata;
        wdata_b = v.rb ? v.wdata : ~v.wdata;
        @(negedge clk);
        chk({tag, " access wr_en"}, 32'(ram_wr_rd_en), 32'(v.we));
        chk({tag, " access addr"}, 32'(ram_address), 32'(v.addr));
        chk({tag, " access bus"}, 32'(ram_data), 32'(v.exp_bus));
        chk({tag, " access no done"}, 32'({done_a, done_b}), 32'd0);
        @(negedge clk);
        chk({tag, " resp done_a"}, 32'(done_a), 32'(v.ra));
        chk({tag, " resp done_b"}, 32'(done_b), 32'(v.rb));
        chk({tag, " resp rdata"}, 32'(rdata), 32'(v.exp_rdata));
        chk({tag, " resp wr_en"}, 32'(ram_wr_rd_en), 32'd0);
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    initial begin
        vec_t v;
        logic exp_b;
        //          ra    rb    we    addr   wdata  bus    rdata
        vecs[0] = '{1'b1, 1'b0, 1'b1, 4'd3,  8'hA5, 8'hA5, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 4'd3,  8'h00, 8'hA5, 8'hA5};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 4'd7,  8'h3C, 8'h3C, 8'hA5};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 4'd7,  8'h00, 8'h3C, 8'h3C};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 4'd15, 8'hFF, 8'hFF, 8'h3C};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 4'd15, 8'h00, 8'hFF, 8'hFF};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 4'd0,  8'h81, 8'h81, 8'hFF};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 4'd0,  8'h00, 8'h81, 8'h81};

        req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        addr_a = 4'd0; addr_b = 4'd0; wdata_a = 8'd0; wdata_b = 8'd0;
        do_reset();

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Both requesters held: three-cycle cadence, winner per arbitration policy.
        do_reset();
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; addr_a = 4'd1; wdata_a = 8'hA1;
        req_b = 1'b1; we_b = 1'b1; addr_b = 4'd2; wdata_b = 8'hB2;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
`ifdef RAM_ARB_RR_EN
            exp_b = (((k - 1) / 3) % 2) == 1;
`else
            exp_b = 1'b0;
`endif
            if ((k % 3) == 1) begin
                chk($sformatf("cont%0d addr", k), 32'(ram_address), exp_b ? 32'd2 : 32'd1);
                chk($sformatf("cont%0d wr_en", k), 32'(ram_wr_rd_en), 32'd1);
            end else begin
                chk($sformatf("cont%0d wr_en", k), 32'(ram_wr_rd_en), 32'd0);
            end
            chk($sformatf("cont%0d done_a", k), 32'(done_a), 32'((k % 3) == 2 && !exp_b));
            chk($sformatf("cont%0d done_b", k), 32'(done_b), 32'((k % 3) == 2 && exp_b));
        end
        req_a = 1'b0;
        req_b = 1'b0;

        // Reset asserted in the middle of a write ACCESS.
        do_reset();
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; addr_a = 4'd2; wdata_a = 8'h5A;
        @(negedge clk);
        chk("midrst pre wr_en", 32'(ram_wr_rd_en), 32'd1);
        chk("midrst pre bus", 32'(ram_data), 32'h5A);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst wr_en", 32'(ram_wr_rd_en), 32'd0);
        chk("midrst bus released", 32'(ram_data), 32'h81);
        chk("midrst ram_address", 32'(ram_address), 32'd0);
        chk("midrst done", 32'({done_a, done_b}), 32'd0);
        req_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("midrst hold%0d done", k), 32'({done_a, done_b}), 32'd0);
        end
        rst_n = 1'b1;
        v = '{1'b0, 1'b1, 1'b1, 4'd0, 8'h11, 8'h11, 8'h00};
        run_txn(v, "post_rst_wr_b");
        v = '{1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h11, 8'h11};
        run_txn(v, "post_rst_rd_a");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_sp_arbiter.md
RAM_SP_ARBITER -- requirements
Module: ram_sp_arbiter

Interface
REQ-001 Parameter data_width, default 8, SHALL set the width of the RAM data word and requester data ports.
REQ-002 Parameter address_width, default 4, SHALL set the width of the RAM and requester addresses.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_a, req_b  input  1 each  SHALL be the access requests, held high until the matching done pulse.
REQ-006 we_a, we_b  input  1 each  SHALL select the operation: 1 = write, 0 = read; valid while the request is high.
REQ-007 addr_a, addr_b  input  address_width each  SHALL be the request addresses.
REQ-008 wdata_a, wdata_b  input  data_width each  SHALL be the write data.
REQ-009 done_a, done_b  output  1 each  SHALL pulse for one cycle when the requester's access completes.
REQ-010 rdata  output  data_width  SHALL be the read data, valid in the cycle done_a or done_b is high for a read.
REQ-011 ram_address  output  address_width  SHALL drive the RAM address.
REQ-012 ram_wr_rd_en  output  1  SHALL drive the RAM mode: 1 = write, 0 = read.
REQ-013 ram_data  inout  data_width  SHALL be the shared RAM data bus.

Function
REQ-014 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-015 In IDLE with at least one request high, the FSM SHALL pick a winner, register its we, addr and wdata, and move to ACCESS on the next edge.
REQ-016 In IDLE with no request high, the FSM SHALL stay in IDLE.
REQ-017 ACCESS SHALL last exactly one cycle: ram_address = registered addr; ram_wr_rd_en = registered we; ram_data = registered wdata when we = 1, else high-Z.
REQ-018 On the edge leaving ACCESS for a read, ram_data SHALL be captured into rdata.
REQ-019 RESP SHALL last one cycle: the winner's done is 1, ram_wr_rd_en = 0, ram_data is high-Z, and the next state is IDLE.
REQ-020 Each access SHALL take 3 cycles from the IDLE sampling edge to done; a new arbitration SHALL occur at most once every 3 cycles.
REQ-021 ram_data SHALL be driven only when the FSM is in ACCESS and ram_wr_rd_en = 1, so the controller never contends with the RAM in read mode.
REQ-022 Outside ACCESS, ram_wr_rd_en SHALL be 0 and ram_address SHALL hold its last value.
REQ-023 rdata SHALL hold its value until the next read capture; writes SHALL NOT modify rdata.
REQ-024 When both requests are high in IDLE, the winner SHALL follow REQ-032.
REQ-025 A request dropped before its done is a protocol violation; the in-flight access SHALL still complete and pulse done.
REQ-026 done_a and done_b SHALL never be high in the same cycle.

Reset
REQ-027 Asserting rst_n low SHALL immediately force the FSM to IDLE with done_a = done_b = 0, ram_wr_rd_en = 0, ram_data high-Z, ram_address = 0 and rdata = 0.
REQ-028 When reset is asserted mid-access, the access SHALL be abandoned with no done pulse; the RAM contents for that address are undefined.
REQ-029 The round-robin pointer SHALL reset to favour requester A.
REQ-030 The first arbitration SHALL occur on the first rising edge after rst_n goes high.

Configuration
REQ-031 Macro RAM_ARB_RR_EN SHALL select the arbitration policy.
REQ-032 With RAM_ARB_RR_EN defined, contention SHALL be resolved round-robin: the requester not served last wins, and the pointer updates only on a grant. Without it, requester A SHALL always win under contention.

Verification
REQ-033 Write, then read back from one requester:
- req_a with we_a = 1, addr_a = 3, wdata_a = 0xA5 -> ram_wr_rd_en = 1 and ram_data = 0xA5 in ACCESS, done_a in the 3rd cycle.
- Then a read of address 3 -> done_a with rdata = 0xA5.
REQ-034 Read bus discipline: req_b reads address 7 (holding 0x3C) -> ram_data is never driven by the controller; rdata = 0x3C with done_b.
REQ-035 Contention with RAM_ARB_RR_EN defined: req_a and req_b held continuously -> grants alternate A, B, A, B, with done every 3 cycles.
REQ-036 Contention without RAM_ARB_RR_EN: both requests held -> A is served repeatedly and done_b never pulses while req_a stays high.
REQ-037 Reset mid-write: rst_n goes low during ACCESS -> ram_wr_rd_en = 0 and ram_data is high-Z immediately, with no done pulse.
- After release, req_b writes 0x11 to address 0 -> done_b in the 3rd cycle.
